control_posicion_rana: RTL and testbench
========================================

# control_posicion_rana

Frog position controller for the game datapath. It sits directly upstream of the frog-count game FSM, and that FSM closes the loop back into this block. It loads the frog at the start cell on the game FSM's frog-init pulse and moves the frog one cell per button press, with a hold-off between moves. It checks the frog cell against the vehicle matrix row every cycle and produces the one-cycle win/lose pulses that the game FSM consumes.

## Interface
- DATAWIDTH_COL, 3: column index width; NCOL = 2**DATAWIDTH_COL columns
- DATAWIDTH_FIL, 3: row index width; row 0 is the top of the screen
- COL_INI, 3: start column
- FIL_INI, 7: start row (bottom)
- FIL_META, 0: goal row
- DATAWIDTH_LOCK, 20: hold-off counter width
- LOCKOUT, 1000000: hold-off length in cycles, must be ≥1

- PR_CLOCK_50  in  1  system clock; single clock domain
- PR_RESET  in  1  synchronous, active-high reset
- PR_RANA_INI  in  1  frog init request from the game FSM
- PR_ARRIBA / PR_ABAJO / PR_IZQ / PR_DER  in  1 each  move buttons, level, active-high, already synchronised
- PR_MATRIZ_FILA  in  NCOL  vehicle occupancy of row PR_FIL_OUT, supplied combinationally by the matrix; bit i = column i
- PR_COL_OUT  out  DATAWIDTH_COL  frog column (registered)
- PR_FIL_OUT  out  DATAWIDTH_FIL  frog row (registered)
- PR_ACTIVA_OUT  out  1  frog alive and in play
- PR_GANO_OUT  out  1  one-cycle pulse: frog reached FIL_META
- PR_PERDIO_OUT  out  1  one-cycle pulse: frog hit a vehicle

## Operation
- States:
  - Espera: idle, no checks.
  - Jugando: accepts moves.
  - Bloqueo: hold-off; ignores buttons.
  - Gano
  - Perdio
- Reset state: Espera. Reset values:
  - COL = COL_INI, FIL = FIL_INI
  - lock counter = 0
  - PR_ACTIVA_OUT = 0, PR_GANO_OUT = 0, PR_PERDIO_OUT = 0
- Outputs are Moore-decoded from the state:
  - PR_ACTIVA_OUT = 1 in Jugando and Bloqueo.
  - PR_GANO_OUT = 1 only in Gano.
  - PR_PERDIO_OUT = 1 only in Perdio.
- Priority, highest first:
  1. PR_RESET
  2. PR_RANA_INI
  3. Collision
  4. Move
- PR_RANA_INI = 1 in any state:
  - Next state is Jugando.
  - COL loads COL_INI, FIL loads FIL_INI.
  - Lock counter clears.
- Collision: in Jugando or Bloqueo, PR_MATRIZ_FILA[PR_COL_OUT] = 1 sends the next state to Perdio. Position holds and any pending move is discarded.
- Moves are accepted only in Jugando with no collision.
  - Button priority: ARRIBA > ABAJO > IZQ > DER; only one move per cycle.
  - ARRIBA: FIL−1. ABAJO: FIL+1. IZQ: COL−1. DER: COL+1.
  - A move that would leave the grid is ignored. The grid limits are FIL < FIL_META, FIL > FIL_INI, COL < 0 and COL > NCOL−1. An ignored move causes no state change and no hold-off, and the next lower-priority button is not substituted.
  - A legal move that lands on FIL_META: position updates and the next state is Gano.
  - Any other legal move: position updates and the next state is Bloqueo with the counter at 0.
- Bloqueo:
  - The counter increments each cycle.
  - At counter = LOCKOUT−1 the next state is Jugando and the counter clears.
  - Bloqueo therefore lasts exactly LOCKOUT cycles.
  - A button held throughout produces one move every LOCKOUT+1 cycles.
- Gano and Perdio last one cycle, then go to Espera. Position holds in both states and in Espera.
- The counter is unsigned, wraps modulo 2**DATAWIDTH_LOCK and is never compared above LOCKOUT−1.

## Timing
- The move edge and the new PR_COL_OUT/PR_FIL_OUT are visible in the same cycle. The matrix then returns the new row's occupancy in that cycle, so collision at the new cell is detected in the first Bloqueo cycle. The Perdio pulse follows one cycle later.
- Init-to-play latency: PR_RANA_INI sampled at edge t gives PR_ACTIVA_OUT = 1 from t+1.
- Win: the move that reaches FIL_META is sampled at edge t. PR_GANO_OUT is high for t+1 only, and the block is in Espera from t+2.
- Collision and win in the same cycle cannot occur, because moves are evaluated only when there is no collision.
- PR_RANA_INI arriving during Gano or Perdio is obeyed: the pulse is truncated to that cycle and the block enters Jugando.
- Reset mid-Bloqueo: the next cycle is Espera with the reset values; the counter does not resume.

## Test plan
- Reset, then PR_RANA_INI pulse -> COL = 3, FIL = 7, PR_ACTIVA_OUT = 1 one cycle after init; GANO, PERDIO and ACTIVA = 0 while in reset.
- LOCKOUT = 4, ARRIBA held from FIL = 7 -> FIL steps 7, 6, 5, … with one decrement every 5 cycles. Reaching FIL = 0 gives PR_GANO_OUT high for exactly 1 cycle, then ACTIVA = 0.
- At COL = 0 press IZQ; at FIL = 7 press ABAJO -> position unchanged, no Bloqueo entered, next DER is accepted in the following cycle.
- PR_MATRIZ_FILA = 8'b0000_1000 with frog at COL = 3 during Bloqueo -> PR_PERDIO_OUT high 1 cycle, position holds, state returns to Espera.
- ARRIBA and DER pressed together with a collision in the same cycle -> Perdio, no position change. Without the collision -> only FIL decrements.
- PR_RANA_INI asserted mid-Bloqueo at (5,2) -> position (3,7), Jugando next cycle, counter cleared. PR_RESET mid-Bloqueo -> Espera, reset values.

Source files
------------

// File: rtl/control_posicion_rana.sv
// rtl/control_posicion_rana.sv - frog position controller with move hold-off and win/lose pulses
// Moves the frog one cell per accepted button press and flags collision against the occupancy row.
module control_posicion_rana #(
  parameter int DATAWIDTH_COL  = 3,
  parameter int DATAWIDTH_FIL  = 3,
  parameter int COL_INI        = 3,
  parameter int FIL_INI        = 7,
  parameter int FIL_META       = 0,
  parameter int DATAWIDTH_LOCK = 20,
  parameter int LOCKOUT        = 1000000
) (
  input  logic                          PR_CLOCK_50,
  input  logic                          PR_RESET,
  input  logic                          PR_RANA_INI,
  input  logic                          PR_ARRIBA,
  input  logic                          PR_ABAJO,
  input  logic                          PR_IZQ,
  input  logic                          PR_DER,
  input  logic [(2**DATAWIDTH_COL)-1:0] PR_MATRIZ_FILA,
  output logic [DATAWIDTH_COL-1:0]      PR_COL_OUT,
  output logic [DATAWIDTH_FIL-1:0]      PR_FIL_OUT,
  output logic                          PR_ACTIVA_OUT,
  output logic                          PR_GANO_OUT,
  output logic                          PR_PERDIO_OUT
);

  localparam logic [2:0] ESPERA  = 3'd0;
  localparam logic [2:0] JUGANDO = 3'd1;
  localparam logic [2:0] BLOQUEO = 3'd2;
  localparam logic [2:0] GANO    = 3'd3;
  localparam logic [2:0] PERDIO  = 3'd4;

  localparam logic [DATAWIDTH_COL-1:0]  COL_INI_C = DATAWIDTH_COL'(COL_INI);
  localparam logic [DATAWIDTH_COL-1:0]  COL_ONE   = DATAWIDTH_COL'(1);
  localparam logic [DATAWIDTH_COL-1:0]  COL_MIN   = '0;
  localparam logic [DATAWIDTH_COL-1:0]  COL_MAX   = '1;
  localparam logic [DATAWIDTH_FIL-1:0]  FIL_INI_C = DATAWIDTH_FIL'(FIL_INI);
  localparam logic [DATAWIDTH_FIL-1:0]  FIL_META_C = DATAWIDTH_FIL'(FIL_META);
  localparam logic [DATAWIDTH_FIL-1:0]  FIL_ONE   = DATAWIDTH_FIL'(1);
  localparam logic [DATAWIDTH_LOCK-1:0] LOCK_LAST = DATAWIDTH_LOCK'(LOCKOUT - 1);
  localparam logic [DATAWIDTH_LOCK-1:0] CNT_ONE   = DATAWIDTH_LOCK'(1);

  logic [2:0]                state_q, state_d;
  logic [DATAWIDTH_COL-1:0]  col_q, col_d, col_mv;
  logic [DATAWIDTH_FIL-1:0]  fil_q, fil_d, fil_mv;
  logic [DATAWIDTH_LOCK-1:0] cnt_q, cnt_d;
  logic                      move_ok;
  logic                      choque;

  assign choque = PR_MATRIZ_FILA[col_q];

  // Only the highest-priority pressed button is considered; if it is blocked by the edge, nothing moves.
  always_comb begin
    move_ok = 1'b0;
    col_mv  = col_q;
    fil_mv  = fil_q;
    if (PR_ARRIBA) begin
      move_ok = (fil_q != FIL_META_C);
      fil_mv  = fil_q - FIL_ONE;
    end else if (PR_ABAJO) begin
      move_ok = (fil_q != FIL_INI_C);
      fil_mv  = fil_q + FIL_ONE;
    end else if (PR_IZQ) begin
      move_ok = (col_q != COL_MIN);
      col_mv  = col_q - COL_ONE;
    end else if (PR_DER) begin
      move_ok = (col_q != COL_MAX);
      col_mv  = col_q + COL_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    fil_d   = fil_q;
    cnt_d   = cnt_q;
    if (PR_RANA_INI) begin
      state_d = JUGANDO;
      col_d   = COL_INI_C;
      fil_d   = FIL_INI_C;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ESPERA: state_d = ESPERA;
        JUGANDO: begin
          if (choque) begin
            state_d = PERDIO;
          end else if (move_ok) begin
            col_d   = col_mv;
            fil_d   = fil_mv;
            cnt_d   = '0;
            state_d = (fil_mv == FIL_META_C) ? GANO : BLOQUEO;
          end
        end
        BLOQUEO: begin
          if (choque) begin
            state_d = PERDIO;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = JUGANDO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        GANO:    state_d = ESPERA;
        PERDIO:  state_d = ESPERA;
        default: state_d = ESPERA;
      endcase
    end
  end

  always_ff @(posedge PR_CLOCK_50) begin
    if (PR_RESET) begin
      state_q <= ESPERA;
      col_q   <= COL_INI_C;
      fil_q   <= FIL_INI_C;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      fil_q   <= fil_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PR_COL_OUT    = col_q;
  assign PR_FIL_OUT    = fil_q;
  assign PR_ACTIVA_OUT = (state_q == JUGANDO) || (state_q == BLOQUEO);
  assign PR_GANO_OUT   = (state_q == GANO);
  assign PR_PERDIO_OUT = (state_q == PERDIO);

endmodule

// File: tb/tb_control_posicion_rana.sv
// tb/tb_control_posicion_rana.sv - scoreboard bench for control_posicion_rana
// Driver queues the expected post-edge outputs; a monitor pops and compares after every edge.
module tb_control_posicion_rana;

  localparam int LOCKOUT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ini = 1'b0;
  logic       arr = 1'b0;
  logic       aba = 1'b0;
  logic       izq = 1'b0;
  logic       der = 1'b0;
  logic [7:0] mat = 8'h00;
  logic [2:0] col_out;
  logic [2:0] fil_out;
  logic       act_out;
  logic       gano_out;
  logic       perd_out;

  always #5 clk = ~clk;

  control_posicion_rana #(
    .DATAWIDTH_COL(3), .DATAWIDTH_FIL(3), .COL_INI(3), .FIL_INI(7),
    .FIL_META(0), .DATAWIDTH_LOCK(20), .LOCKOUT(LOCKOUT)
  ) dut (
    .PR_CLOCK_50(clk),
    .PR_RESET(rst),
    .PR_RANA_INI(ini),
    .PR_ARRIBA(arr),
    .PR_ABAJO(aba),
    .PR_IZQ(izq),
    .PR_DER(der),
    .PR_MATRIZ_FILA(mat),
    .PR_COL_OUT(col_out),
    .PR_FIL_OUT(fil_out),
    .PR_ACTIVA_OUT(act_out),
    .PR_GANO_OUT(gano_out),
    .PR_PERDIO_OUT(perd_out)
  );

  typedef struct packed {
    logic [2:0] col;
    logic [2:0] fil;
    logic       act;
    logic       gano;
    logic       perd;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  obs_t  e_m;
  obs_t  g_m;
  string nm_m;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e_m  = exp_q.pop_front();
      nm_m = name_q.pop_front();
      g_m  = '{col: col_out, fil: fil_out, act: act_out, gano: gano_out, perd: perd_out};
      n_chk++;
      if (g_m === e_m) n_pass++;
      else $display("FAIL %s: got col=%0d fil=%0d act=%b gano=%b perdio=%b, expected col=%0d fil=%0d act=%b gano=%b perdio=%b",
                    nm_m, g_m.col, g_m.fil, g_m.act, g_m.gano, g_m.perd,
                    e_m.col, e_m.fil, e_m.act, e_m.gano, e_m.perd);
    end
  end

  task automatic step(input logic r, i, a, b, l, d, input logic [7:0] m,
                      input logic [2:0] ec, ef, input logic ea, eg, ep, input string nm);
    @(negedge clk);
    rst = r; ini = i; arr = a; aba = b; izq = l; der = d; mat = m;
    exp_q.push_back('{col: ec, fil: ef, act: ea, gano: eg, perd: ep});
    name_q.push_back(nm);
    @(posedge clk);
  endtask

  task automatic mv(input logic a, b, l, d, input logic [2:0] ec, ef, input string nm);
    step(0, 0, a, b, l, d, 8'h00, ec, ef, 1, 0, 0, nm);
    repeat (LOCKOUT) step(0, 0, 0, 0, 0, 0, 8'h00, ec, ef, 1, 0, 0, {nm, "_lock"});
  endtask

  initial begin
    // reset and init
    step(1, 0, 0, 0, 0, 0, 8'h00, 3'd3, 3'd7, 0, 0, 0, "reset0");
    step(1, 0, 1, 0, 0, 0, 8'hFF, 3'd3, 3'd7, 0, 0, 0, "reset1");
    step(0, 1, 0, 0, 0, 0, 8'h00, 3'd3, 3'd7, 1, 0, 0, "init");

    // ARRIBA held: one step every LOCKOUT+1 cycles, then the win pulse
    for (int f = 6; f >= 1; f--) begin
      step(0, 0, 1, 0, 0, 0, 8'h00, 3'd3, 3'(f), 1, 0, 0, "hold_up_move");
      repeat (LOCKOUT) step(0, 0, 1, 0, 0, 0, 8'h00, 3'd3, 3'(f), 1, 0, 0, "hold_up_lock");
    end
    step(0, 0, 1, 0, 0, 0, 8'h00, 3'd3, 3'd0, 0, 1, 0, "win");
    step(0, 0, 1, 0, 0, 0, 8'h00, 3'd3, 3'd0, 0, 0, 0, "win_end");
    step(0, 0, 1, 0, 0, 0, 8'h00, 3'd3, 3'd0, 0, 0, 0, "espera_hold");

    // grid edges
    step(0, 1, 0, 0, 0, 0, 8'h00, 3'd3, 3'd7, 1, 0, 0, "reinit");
    mv(0, 0, 1, 0, 3'd2, 3'd7, "izq1");
    mv(0, 0, 1, 0, 3'd1, 3'd7, "izq2");
    mv(0, 0, 1, 0, 3'd0, 3'd7, "izq3");
    step(0, 0, 0, 0, 1, 0, 8'h00, 3'd0, 3'd7, 1, 0, 0, "izq_edge");
    step(0, 0, 0, 1, 0, 0, 8'h00, 3'd0, 3'd7, 1, 0, 0, "abajo_edge");
    step(0, 0, 0, 0, 1, 1, 8'h00, 3'd0, 3'd7, 1, 0, 0, "no_subst");
    mv(0, 0, 0, 1, 3'd1, 3'd7, "der_after");

    // collision during Bloqueo
    mv(0, 0, 0, 1, 3'd2, 3'd7, "der2");
    step(0, 0, 0, 0, 0, 1, 8'h00, 3'd3, 3'd7, 1, 0, 0, "der3");
    step(0, 0, 0, 0, 0, 0, 8'h08, 3'd3, 3'd7, 0, 0, 1, "collide_lock");
    step(0, 0, 0, 0, 0, 0, 8'h08, 3'd3, 3'd7, 0, 0, 0, "perdio_end");

    // collision beats a simultaneous move; init during Perdio
    step(0, 1, 0, 0, 0, 0, 8'h00, 3'd3, 3'd7, 1, 0, 0, "init_again");
    step(0, 0, 1, 0, 0, 1, 8'h08, 3'd3, 3'd7, 0, 0, 1, "both_collide");
    step(0, 1, 0, 0, 0, 0, 8'h00, 3'd3, 3'd7, 1, 0, 0, "ini_in_perdio");
    mv(1, 0, 0, 1, 3'd3, 3'd6, "both_clear");

    // init mid-Bloqueo at (5,2)
    mv(0, 0, 0, 1, 3'd4, 3'd6, "to5a");
    mv(0, 0, 0, 1, 3'd5, 3'd6, "to5b");
    mv(1, 0, 0, 0, 3'd5, 3'd5, "up5");
    mv(1, 0, 0, 0, 3'd5, 3'd4, "up4");
    mv(1, 0, 0, 0, 3'd5, 3'd3, "up3");
    step(0, 0, 1, 0, 0, 0, 8'h00, 3'd5, 3'd2, 1, 0, 0, "up2");
    step(0, 0, 0, 0, 0, 0, 8'h00, 3'd5, 3'd2, 1, 0, 0, "lock52");
    step(0, 1, 0, 0, 0, 0, 8'h00, 3'd3, 3'd7, 1, 0, 0, "ini_mid_lock");
    step(0, 0, 0, 0, 0, 1, 8'h00, 3'd4, 3'd7, 1, 0, 0, "post_ini_der");

    // reset mid-Bloqueo
    step(0, 0, 0, 0, 0, 0, 8'h00, 3'd4, 3'd7, 1, 0, 0, "lock47");
    step(1, 0, 0, 0, 0, 0, 8'h00, 3'd3, 3'd7, 0, 0, 0, "rst_mid_lock");
    step(0, 0, 1, 0, 0, 0, 8'h00, 3'd3, 3'd7, 0, 0, 0, "no_resume");
    repeat (LOCKOUT + 1) step(0, 0, 0, 0, 0, 0, 8'h00, 3'd3, 3'd7, 0, 0, 0, "stay_espera");
    step(0, 1, 1, 0, 0, 0, 8'h00, 3'd3, 3'd7, 1, 0, 0, "ini_prio");

    @(negedge clk);
    rst = 0; ini = 0; arr = 0; aba = 0; izq = 0; der = 0; mat = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
